add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_pkg.sv | 14 +
 rtl/add8_slice.sv | 14 +
 rtl/add_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract controller.
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;
   localparam int   SLICE_W = 8;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit ripple slice: s = a + b + cin, cout = carry out.
module add8_slice
   import add_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// Byte-serial add/sub: one 8-bit slice per cycle, result valid WORDS cycles after accept.
// Backpressure: result held in DONE until out_ready; no new request accepted until IDLE.
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*WORDS-1:0]   in_a,
   input  logic [8*WORDS-1:0]   in_b,
   input  logic                 in_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*WORDS-1:0]   out_sum,
   output logic                 out_cout,
   output logic                 out_ovf,
   output logic                 busy
);

   localparam int W    = SLICE_W * WORDS;
   localparam int IDXW = $clog2(WORDS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
   logic               sl_cout;

   assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
   assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

   add8_slice u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_cout)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      if (clear) begin
         state_d = IDLE;
         idx_d   = '0;
         carry_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // B is stored pre-inverted so subtraction is A + ~B + 1 through the same slice.
                  a_d     = in_a;
                  b_d     = in_b ^ {W{in_op}};
                  idx_d   = '0;
                  carry_d = (in_op == OP_SUB);
                  state_d = RUN;
               end
            end
            RUN: begin
               sum_d[idx_q*SLICE_W +: SLICE_W] = sl_s;
               carry_d = sl_cout;
               idx_d   = idx_q + IDXW'(1);
               if (idx_q == LAST_IDX) begin
                  cout_d  = sl_cout;
                  ovf_d   = (a_q[W-1] == b_q[W-1]) && (sl_s[SLICE_W-1] != a_q[W-1]);
                  idx_d   = '0;
                  state_d = DONE;
               end
            end
            DONE: begin
               if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl (WORDS=4): directed corner cases plus randomized streams vs an arithmetic model.
module tb_add_seq_ctrl;

   localparam int WORDS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        in_op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   add_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {cout, ovf, sum} from integer arithmetic on the operands' values.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
      longint sa, sb, r;
      longint unsigned ua, ub;
      logic [31:0] s;
      logic c, v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = op ? (sa - sb) : (sa + sb);
      v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      c  = op ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
      s  = op ? (a - b) : (a + b);
      return {c, v, s};
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [63:0] res();
      return {30'd0, out_cout, out_ovf, out_sum};
   endfunction

   // Accept one op, check latency and result, stall 'hold' cycles in DONE, then drain.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [33:0] exp, input int hold);
      int n;
      @(negedge clk);
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, "/latency"}, 64'(n), 64'(WORDS));
      chk({tag, "/result"}, res(), {30'd0, exp});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "/hold_result"}, res(), {30'd0, exp});
         chk({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "/drained"}, {62'd0, out_valid, in_ready}, 64'd1);
   endtask

   // Random stream; in_valid held whenever requests remain.
   task automatic stream(input string tag, input int nreq, input bit rand_ready);
      logic [33:0] q[$];
      int sent, got, cyc;
      logic [31:0] a, b;
      logic op, acc, ret;
      sent = 0; got = 0; cyc = 0;
      a = rnd_word(); b = rnd_word(); op = 1'($urandom_range(0, 1));
      while (got < nreq && cyc < 3000) begin
         @(negedge clk);
         in_valid  = (sent < nreq);
         in_a = a; in_b = b; in_op = op;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         acc = in_valid && in_ready;
         ret = out_valid && out_ready;
         if (ret) begin
            if (q.size() == 0) chk({tag, "/spurious"}, 64'(q.size()), 64'd1);
            else chk({tag, "/result"}, res(), {30'd0, q.pop_front()});
            got++;
         end
         @(posedge clk);
         cyc++;
         if (acc) begin
            q.push_back(model(a, b, op));
            sent++;
            a = rnd_word(); b = rnd_word(); op = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      chk({tag, "/count"}, 64'(got), 64'(nreq));
      chk({tag, "/leftover"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      bit seen;

      #2 rst_n = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset/outputs", {28'd0, in_ready, out_valid, busy, out_cout, out_ovf, 27'd0},
          {28'd0, 1'b1, 4'b0000, 27'd0});
      chk("reset/sum", 64'(out_sum), 64'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset/idle_after", {62'd0, busy, in_ready}, 64'd1);

      do_op("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0000_0100}, 0);
      do_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h0000_0000}, 0);
      do_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 32'h8000_0000}, 0);
      do_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, 0);
      do_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, 0);
      do_op("stall5",     32'h1234_5678, 32'h0F0F_0F0F, 1'b0, model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0), 5);

      // Handshake edge with in_valid already high: accepted only one edge later.
      do_op("pre_chain", 32'hA5A5_0000, 32'h0000_5A5A, 1'b1, model(32'hA5A5_0000, 32'h0000_5A5A, 1'b1), 2);
      @(negedge clk);
      in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_op = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("chain/accepted", 64'(busy), 64'd1);
      in_valid = 1'b0;
      repeat (WORDS) @(posedge clk);
      @(negedge clk);
      chk("chain/result", {63'd0, out_valid}, 64'd1);
      chk("chain/sum", res(), 64'h0000_0030);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Clear at idx==2 aborts the operation.
      in_a = 32'h0101_0101; in_b = 32'h0202_0202; in_op = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("clear/busy_before", 64'(busy), 64'd1);
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      chk("clear/idle", {61'd0, in_ready, busy, out_valid}, 64'b100);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("clear/no_valid", 64'(seen), 64'd0);

      // Async reset pulse mid-RUN.
      in_a = 32'hDEAD_BEEF; in_b = 32'h1111_1111; in_op = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid/outputs", {28'd0, in_ready, out_valid, busy, out_cout, out_ovf, 27'd0},
          {28'd0, 1'b1, 4'b0000, 27'd0});
      chk("rst_mid/sum", 64'(out_sum), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rst_mid/no_valid", 64'(seen), 64'd0);

      stream("stream3", 3, 1'b0);
      stream("stream_rand", 25, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
